// File: rtl/nn_feature_loader.sv
// nn_feature_loader: assembles N_FEAT feature words into a vector, holds it for the classifier latency, then hands off the class.
// Optional macro FEAT_LAST_CHECK_EN enables feat_last framing checks that drive frame_err.
module nn_feature_loader #(
    parameter int N_FEAT     = 16,
    parameter int NN_LATENCY = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [15:0]              feat_data,
    input  logic                            feat_valid,
    input  logic                            feat_last,
    output logic                            feat_ready,
    output logic signed [N_FEAT-1:0][15:0]  input_vector,
    input  logic [1:0]                      nn_class,
    output logic [1:0]                      class_id,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic                            frame_err
);
    localparam int IW = $clog2(N_FEAT);
    localparam int CW = $clog2(NN_LATENCY + 1);

    typedef enum logic [1:0] {S_FILL, S_WAIT, S_RESULT} state_t;

    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic beat, last_word, ferr, done, hs;

`ifndef FEAT_LAST_CHECK_EN
    logic unused_last;
    assign unused_last = feat_last;
`endif

    always_comb begin
        feat_ready = state == S_FILL;
        beat       = feat_ready && feat_valid;
        last_word  = idx == IW'(N_FEAT - 1);
`ifdef FEAT_LAST_CHECK_EN
        ferr       = beat && (feat_last != last_word);
`else
        ferr       = 1'b0;
`endif
        done       = state == S_WAIT && cnt == CW'(NN_LATENCY);
        hs         = state == S_RESULT && result_ready;
        state_nx   = state;
        if (beat && last_word && !ferr)
            state_nx = S_WAIT;
        else if (done)
            state_nx = S_RESULT;
        else if (hs)
            state_nx = S_FILL;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_FILL;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx          <= '0;
            cnt          <= '0;
            input_vector <= '0;
            class_id     <= '0;
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_err <= ferr;
            if (beat) begin
                idx <= (ferr || last_word) ? '0 : idx + 1'b1;
                if (!ferr)
                    input_vector[idx] <= feat_data;
            end
            // counter runs only while waiting so it starts at 0 for each frame
            cnt <= (state == S_WAIT && !done) ? cnt + 1'b1 : '0;
            if (done) begin
                class_id     <= nn_class;
                result_valid <= 1'b1;
            end else if (hs) begin
                result_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_nn_feature_loader.sv
// tb_nn_feature_loader: directed self-checking bench for nn_feature_loader.
module tb_nn_feature_loader;
    logic                      clk = 0;
    logic                      rst;
    logic signed [15:0]        feat_data;
    logic                      feat_valid;
    logic                      feat_last;
    logic                      feat_ready;
    logic signed [15:0][15:0]  input_vector;
    logic [1:0]                nn_class;
    logic [1:0]                class_id;
    logic                      result_valid;
    logic                      result_ready;
    logic                      frame_err;

    int n_chk = 0;
    int n_fail = 0;

    nn_feature_loader #(.N_FEAT(16), .NN_LATENCY(4)) dut (
        .clk(clk), .rst(rst), .feat_data(feat_data), .feat_valid(feat_valid),
        .feat_last(feat_last), .feat_ready(feat_ready), .input_vector(input_vector),
        .nn_class(nn_class), .class_id(class_id), .result_valid(result_valid),
        .result_ready(result_ready), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input int base);
        logic [15:0] e;
        for (int i = 0; i < 16; i++) begin
            e = 16'(base + i);
            check($sformatf("%s[%0d]", tag, i), input_vector[i], e);
        end
    endtask

    task automatic send_frame(input string tag, input int base, input bit gapped);
        for (int i = 0; i < 16; i++) begin
            feat_valid = 1;
            feat_data  = 16'(base + i);
            step;
            if (gapped && i < 15) begin
                feat_valid = 0;
                feat_data  = 16'hdead;
                step;
            end
        end
        feat_valid = 0;
        check({tag, "_ready_low_E0"}, {15'd0, feat_ready}, 16'd0);
    endtask

    // called right after E0; result must rise exactly at E0+5
    task automatic expect_result(input string tag, input logic [1:0] cls);
        for (int k = 1; k <= 4; k++) begin
            step;
            check($sformatf("%s_rv_early%0d", tag, k), {15'd0, result_valid}, 16'd0);
        end
        step;
        check({tag, "_rv"}, {15'd0, result_valid}, 16'd1);
        check({tag, "_class"}, {14'd0, class_id}, {14'd0, cls});
    endtask

    task automatic accept(input string tag);
        result_ready = 1;
        step;
        result_ready = 0;
        check({tag, "_rv_drop"}, {15'd0, result_valid}, 16'd0);
        check({tag, "_ready_back"}, {15'd0, feat_ready}, 16'd1);
    endtask

    initial begin
        int nb;
        logic fe_exp;
        rst = 0; feat_data = 0; feat_valid = 0; feat_last = 0;
        nn_class = 0; result_ready = 0;
        repeat (2) step;
        check("rst_rv", {15'd0, result_valid}, 16'd0);
        check("rst_class", {14'd0, class_id}, 16'd0);
        check("rst_ready", {15'd0, feat_ready}, 16'd1);
        check("rst_ferr", {15'd0, frame_err}, 16'd0);
        for (int i = 0; i < 16; i++)
            check($sformatf("rst_vec[%0d]", i), input_vector[i], 16'd0);
        rst = 1;
        step;

        // back-to-back frame, result held under backpressure
        nn_class = 2'd3;
        send_frame("b2b", 1, 0);
        feat_valid = 1;
        feat_data  = 16'h7777;
        expect_result("b2b", 2'd3);
        check_vec("b2b_vec", 1);
        nn_class = 2'd0;
        for (int k = 0; k < 10; k++) begin
            step;
            check($sformatf("bp_class%0d", k), {14'd0, class_id}, 16'd3);
            check($sformatf("bp_rv%0d", k), {15'd0, result_valid}, 16'd1);
            check($sformatf("bp_ready%0d", k), {15'd0, feat_ready}, 16'd0);
        end
        check_vec("bp_vec", 1);
        feat_valid = 0;
        accept("bp");

        // gapped input
        nn_class = 2'd1;
        send_frame("gap", 100, 1);
        expect_result("gap", 2'd1);
        check_vec("gap_vec", 100);
        accept("gap");

        // mid-frame reset after 7 beats
        for (int i = 0; i < 7; i++) begin
            feat_valid = 1;
            feat_data  = 16'(300 + i);
            step;
        end
        feat_valid = 0;
        check("pre_rst_vec6", input_vector[6], 16'd306);
        rst = 0;
        step;
        rst = 1;
        check("mrst_vec0", input_vector[0], 16'd0);
        check("mrst_vec6", input_vector[6], 16'd0);
        check("mrst_ready", {15'd0, feat_ready}, 16'd1);
        check("mrst_rv", {15'd0, result_valid}, 16'd0);
        nn_class = 2'd2;
        send_frame("mrst", 200, 0);
        expect_result("mrst", 2'd2);
        check_vec("mrst_vec", 200);
        accept("mrst");

        // framing: feat_last on beat 5 and on the 21st beat
`ifdef FEAT_LAST_CHECK_EN
        nb = 21;
`else
        nb = 16;
`endif
        nn_class = 2'd1;
        for (int j = 0; j < nb; j++) begin
            feat_valid = 1;
            feat_data  = 16'(16'hF000 + j);
            feat_last  = (j == 4) || (j == 20);
            step;
`ifdef FEAT_LAST_CHECK_EN
            fe_exp = (j == 4);
`else
            fe_exp = 0;
`endif
            check($sformatf("fr_ferr%0d", j), {15'd0, frame_err}, {15'd0, fe_exp});
            if (j < nb - 1)
                check($sformatf("fr_ready%0d", j), {15'd0, feat_ready}, 16'd1);
        end
        feat_valid = 0;
        feat_last  = 0;
        check("fr_ready_low_E0", {15'd0, feat_ready}, 16'd0);
        expect_result("fr", 2'd1);
        check("fr_ferr_quiet", {15'd0, frame_err}, 16'd0);
`ifdef FEAT_LAST_CHECK_EN
        check_vec("fr_vec", 32'hF005);
`else
        check_vec("fr_vec", 32'hF000);
`endif
        accept("fr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
